// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall arbitration, exception/ERET flush with
// post-flush hold-off, stall-cycle counter and stuck-stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h00000020,
  parameter int unsigned HOLDOFF_CYCLES = 2,
  parameter int unsigned STALL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  localparam logic [31:0] EXC_ERET  = 32'h0000000e;
  localparam logic [3:0]  HOLD_LOAD = 4'(HOLDOFF_CYCLES);
  localparam logic [15:0] LIMIT     = 16'(STALL_LIMIT);

  typedef enum logic {
    RUN,
    HOLDOFF
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  hold_cnt;
  logic [15:0] consec;
  logic        stall_active;

  always_comb begin
    stall    = '0;
    flush    = 1'b0;
    new_pc   = '0;
    state_nx = state;
    case (state)
      RUN: begin
        // Exception wins over any stall request in the same cycle.
        if (excepttype_i != '0) begin
          flush    = 1'b1;
          new_pc   = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          state_nx = HOLDOFF;
        end else if (stallreq_from_mem) begin
          stall = 6'b011111;
        end else if (stallreq_from_ex) begin
          stall = 6'b001111;
        end else if (stallreq_from_id) begin
          stall = 6'b000111;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == 4'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign stall_active = (stall != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      hold_cnt      <= '0;
      stall_cycles  <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (flush) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLDOFF && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end

      if (stall_active) begin
        stall_cycles <= stall_cycles + 32'd1;
        if (consec != LIMIT) consec <= consec + 16'd1;
        // Flag on the edge the counter reaches the limit, then stick.
        if (consec >= LIMIT - 16'd1) stall_timeout <= 1'b1;
      end else begin
        consec <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table followed by
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int HOLD  = 2;
  localparam int LIMIT = 4;
  localparam logic [31:0] VEC = 32'h00000020;

  logic        clk;
  logic        rst;
  logic        id_r, ex_r, mem_r;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  pipe_ctrl #(
    .EXC_VECTOR    (VEC),
    .HOLDOFF_CYCLES(HOLD),
    .STALL_LIMIT   (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (id_r),
    .stallreq_from_ex (ex_r),
    .stallreq_from_mem(mem_r),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_cycles     (stall_cycles),
    .stall_timeout    (stall_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles of hold-off left, counters, sticky flag.
  int          m_hold = 0;
  int unsigned m_sc = 0;
  int          m_consec = 0;
  bit          m_to = 0;

  task automatic model_out(input logic i, input logic e, input logic m,
                           input logic [31:0] x, input logic [31:0] p,
                           output logic [5:0] s, output logic f, output logic [31:0] pc);
    int frozen;
    s = '0; f = 1'b0; pc = '0;
    if (m_hold > 0) return;
    if (x != 0) begin
      f  = 1'b1;
      pc = (x == 32'he) ? p : VEC;
      return;
    end
    frozen = m ? 5 : e ? 4 : i ? 3 : 0;
    s = 6'((1 << frozen) - 1);
  endtask

  task automatic model_edge(input logic r, input logic [5:0] s, input logic f);
    if (r) begin
      m_hold = 0; m_sc = 0; m_consec = 0; m_to = 0;
      return;
    end
    if (m_hold > 0) m_hold--;
    else if (f) m_hold = HOLD;
    if (s != 0) begin
      m_sc++;
      if (m_consec < LIMIT) m_consec++;
      if (m_consec == LIMIT) m_to = 1;
    end else begin
      m_consec = 0;
    end
  endtask

  // One cycle: drive, sample at negedge, advance model on posedge.
  task automatic cycle(input logic r, input logic i, input logic e, input logic m,
                       input logic [31:0] x, input logic [31:0] p,
                       input bit use_tbl, input logic [5:0] ts, input logic tf,
                       input logic [31:0] tpc, input logic tto);
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    rst = r; id_r = i; ex_r = e; mem_r = m; exc = x; epc = p;
    model_out(i, e, m, x, p, s, f, pc);
    @(negedge clk);
    if (!r) begin
      check("stall", 32'(stall), use_tbl ? 32'(ts) : 32'(s));
      check("flush", 32'(flush), use_tbl ? 32'(tf) : 32'(f));
      if (use_tbl ? tf : f) check("new_pc", new_pc, use_tbl ? tpc : pc);
      check("stall_cycles", stall_cycles, m_sc);
      check("stall_timeout", 32'(stall_timeout), use_tbl ? 32'(tto) : 32'(m_to));
    end
    @(posedge clk);
    model_edge(r, s, f);
    #1;
  endtask

  typedef struct {
    logic        r, i, e, m;
    logic [31:0] x, p;
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic i, input logic e, input logic m,
                              input logic [31:0] x, input logic [31:0] p,
                              input logic [5:0] s, input logic f,
                              input logic [31:0] pc, input logic to);
    vec_t v;
    v.r = r; v.i = i; v.e = e; v.m = m; v.x = x; v.p = p;
    v.s = s; v.f = f; v.pc = pc; v.to = to;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; id_r = 0; ex_r = 0; mem_r = 0; exc = '0; epc = '0;

    // reset, idle
    add(1, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    // watchdog: ex x3, release, ex x4 -> trips on 4th edge of second burst
    for (int k = 0; k < 3; k++) add(0, 0,1,0, 0, 0, 6'h0f, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0,1,0, 0, 0, 6'h0f, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 1);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 1);
    add(1, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    // id x3 then ex+mem x2
    for (int k = 0; k < 3; k++) add(0, 1,0,0, 0, 0, 6'h07, 0, 0, 0);
    add(0, 0,1,1, 0, 0, 6'h1f, 0, 0, 0);
    add(0, 0,1,1, 0, 0, 6'h1f, 0, 0, 1);
    // syscall with mem stall held throughout
    add(0, 0,0,1, 32'h8, 0, 6'h00, 1, VEC, 1);
    add(0, 0,0,1, 0, 0, 6'h00, 0, 0, 1);
    add(0, 0,0,1, 0, 0, 6'h00, 0, 0, 1);
    add(0, 0,0,1, 0, 0, 6'h1f, 0, 0, 1);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 1);
    // ERET, then interrupt dropped during hold-off
    add(0, 0,0,0, 32'he, 32'hBFC00104, 6'h00, 1, 32'hBFC00104, 1);
    add(0, 0,0,0, 32'h1, 0, 6'h00, 0, 0, 1);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 1);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 1);
    // reset in first hold-off cycle, then exception right after
    add(0, 0,0,0, 32'h8, 0, 6'h00, 1, VEC, 1);
    add(1, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 0,0,0, 32'hc, 0, 6'h00, 1, VEC, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 0,0,0, 0, 0, 6'h00, 0, 0, 0);

    foreach (tbl[n])
      cycle(tbl[n].r, tbl[n].i, tbl[n].e, tbl[n].m, tbl[n].x, tbl[n].p,
            1'b1, tbl[n].s, tbl[n].f, tbl[n].pc, tbl[n].to);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r, i, e, m;
      logic [31:0] x, p;
      r = ($urandom_range(0, 299) == 0);
      i = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 2) == 0);
      p = $urandom;
      x = '0;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 4))
          0: x = 32'h8;
          1: x = 32'he;
          2: x = 32'h1;
          3: x = 32'hc;
          default: x = $urandom | 32'h1;
        endcase
      end
      cycle(r, i, e, m, x, p, 1'b0, '0, 1'b0, '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Arbitrates stall requests from ID, EX and MEM into the 6-bit stall vector consumed by pc_reg and all inter-stage registers, including the EX/MEM register.
- Sequences exception/ERET redirection: issues flush and new_pc, then enforces a post-flush hold-off window.
- Maintains a stall-cycle counter and a stuck-stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, target PC for all non-ERET exceptions.
- HOLDOFF_CYCLES, 2, cycles after a flush during which new exceptions and stall requests are ignored (range 1..15).
- STALL_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (range 2..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1).
- stallreq_from_id  in  1  ID stage requests a stall.
- stallreq_from_ex  in  1  EX stage requests a stall (multi-cycle div/madd).
- stallreq_from_mem  in  1  MEM stage requests a stall (bus wait).
- excepttype_i  in  32  exception code from the MEM stage; 0 means none.
- cp0_epc_i  in  32  current CP0 EPC, already forwarded.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = STOP.
- flush  out  1  clears all pipeline registers on the next edge.
- new_pc  out  32  redirect target; valid only while flush = 1.
- stall_cycles  out  32  count of cycles with stall != 0.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values (sampled on posedge clk with rst = 1):
  - state = RUN; stall = 0; flush = 0; new_pc = 0.
  - stall_cycles = 0; stall_timeout = 0; internal consecutive-stall counter = 0; hold-off counter = 0.
- Reset overrides everything, including mid-hold-off and mid-stall.
- State machine states: RUN, HOLDOFF.
- Flush in RUN:
  - flush = 1 combinationally in the same cycle that excepttype_i != 0. Zero latency, so every pipeline register clears on that edge.
  - new_pc = cp0_epc_i when excepttype_i == 32'h0000000e (ERET); otherwise EXC_VECTOR.
  - On that edge, go to HOLDOFF and load the hold-off counter with HOLDOFF_CYCLES.
- Flush has priority over stall: stall = 6'b000000 whenever flush = 1.
- Stall arbitration in RUN with no exception (combinational, highest stage wins):
  - mem → 6'b011111.
  - else ex → 6'b001111.
  - else id → 6'b000111.
  - else 6'b000000.
- HOLDOFF state:
  - flush = 0, new_pc = 0, stall = 0.
  - excepttype_i and all stall requests are ignored.
  - The hold-off counter decrements each cycle; on the cycle it reads 1, the next state is RUN.
  - The window is exactly HOLDOFF_CYCLES cycles.
- Flush outside RUN: flush is never asserted in HOLDOFF. An exception present only during HOLDOFF is dropped.
- stall_cycles:
  - Increments by 1 on each edge where stall != 0.
  - Wraps from 32'hFFFFFFFF to 0.
  - Does not increment on flush cycles.
- Watchdog (consecutive-stall counter):
  - Increments on each edge with stall != 0.
  - Clears to 0 on any edge with stall == 0, including all HOLDOFF and flush cycles.
  - Saturates at STALL_LIMIT.
  - When it reaches STALL_LIMIT, stall_timeout is set to 1 on that edge and stays 1 until rst.
  - The watchdog does not alter stall.
- Simultaneous events:
  - An exception and any stall request in the same RUN cycle produce flush = 1 and stall = 0.
  - A stall request arriving on the last HOLDOFF cycle is ignored; it takes effect in the first RUN cycle if still held.
- Requesters must hold their request level until served; this block does not latch requests.

Test Plan:
- Reset, then rst = 0 with all requests low → stall = 0, flush = 0, new_pc = 0, stall_cycles = 0, stall_timeout = 0.
- stallreq_from_id = 1 for 3 cycles, then stallreq_from_ex = 1 and stallreq_from_mem = 1 together for 2 cycles → stall = 6'b000111 ×3, then 6'b011111 ×2; stall_cycles = 5.
- excepttype_i = 32'h8 (syscall) for 1 cycle, with stallreq_from_mem = 1 throughout → that cycle flush = 1, new_pc = 32'h00000020, stall = 0. The next 2 cycles flush = 0, stall = 0 (HOLDOFF). The cycle after that stall = 6'b011111.
- excepttype_i = 32'he with cp0_epc_i = 32'hBFC00104, then excepttype_i = 32'h1 on the following cycle → one flush with new_pc = 32'hBFC00104; the interrupt cycle shows flush = 0 (dropped in HOLDOFF).
- STALL_LIMIT = 4: stallreq_from_ex held for 3 cycles, released for 1 cycle, then held for 4 cycles → stall_timeout stays 0 through the first burst and rises on the 4th edge of the second burst. It stays 1 after release and clears only on rst.
- rst = 1 asserted in the 1st HOLDOFF cycle, then released with excepttype_i = 32'hc → state is RUN immediately; flush = 1 and new_pc = 32'h00000020 in the first cycle after reset.
